// File: rtl/dds_multi_ch.sv
// dds_multi_ch: CH_NUM-channel DDS with shadow/active config, linear sweep, amplitude and offset scaling; sine ROM only with DDS_SINE_LUT_EN.
// Latency: accumulator to data_out 3 cycles, config delay-matched.
// Backpressure: none, free-running output every cycle.
module dds_multi_ch #(
    parameter int CH_NUM  = 2,
    parameter int ACC_W   = 32,
    parameter int PHASE_W = 12,
    parameter int OUT_W   = 8,
    parameter int AMP_W   = 9,
    localparam int CH_W   = (CH_NUM > 1) ? $clog2(CH_NUM) : 1
) (
    input  logic                    sys_clk,
    input  logic                    sys_rst,
    input  logic                    cfg_we,
    input  logic [CH_W-1:0]         cfg_ch,
    input  logic [2:0]              cfg_addr,
    input  logic [31:0]             cfg_wdata,
    input  logic                    cfg_update,
    input  logic                    cfg_sync,
    output logic [CH_NUM*OUT_W-1:0] data_out,
    output logic                    out_valid,
    output logic [CH_NUM-1:0]       sweep_done
);

    localparam int SC_W   = OUT_W + AMP_W - 8;
    localparam int PROD_W = OUT_W + AMP_W;
    localparam logic [AMP_W-1:0] AMP_UNITY = AMP_W'(256);
    localparam logic [OUT_W-1:0] HALF      = {1'b1, {(OUT_W-1){1'b0}}};

    typedef struct packed {
        logic [ACC_W-1:0]   freq;
        logic [PHASE_W-1:0] phase;
        logic [AMP_W-1:0]   amp;
        logic [OUT_W-1:0]   offset;
        logic [3:0]         mode;
        logic [ACC_W-1:0]   step;
        logic [ACC_W-1:0]   smax;
        logic [15:0]        sdiv;
    } cfg_t;

    typedef struct packed {
        logic [PHASE_W-1:0] phase;
        logic [2:0]         wave;
        logic [AMP_W-1:0]   amp;
        logic [OUT_W-1:0]   offset;
    } meta_t;

    localparam cfg_t CFG_RST = '{freq: '0, phase: '0, amp: AMP_UNITY, offset: '0,
                                 mode: '0, step: '0, smax: '1, sdiv: '0};
    localparam meta_t META_RST = '{phase: '0, wave: '0, amp: AMP_UNITY, offset: '0};

    cfg_t               shadow_q   [CH_NUM];
    cfg_t               shadow_d   [CH_NUM];
    cfg_t               active_q   [CH_NUM];
    cfg_t               active_d   [CH_NUM];
    logic [ACC_W-1:0]   acc_q      [CH_NUM];
    logic [ACC_W-1:0]   acc_d      [CH_NUM];
    logic [ACC_W-1:0]   freq_cur_q [CH_NUM];
    logic [ACC_W-1:0]   freq_cur_d [CH_NUM];
    logic [15:0]        div_q      [CH_NUM];
    logic [15:0]        div_d      [CH_NUM];
    logic [CH_NUM-1:0]  sweep_done_q;
    logic [CH_NUM-1:0]  sweep_done_d;
    meta_t              meta1_q    [CH_NUM];
    meta_t              meta1_d    [CH_NUM];
    logic [OUT_W-1:0]   raw_q      [CH_NUM];
    logic [OUT_W-1:0]   raw_d      [CH_NUM];
    logic [AMP_W-1:0]   amp2_q     [CH_NUM];
    logic [AMP_W-1:0]   amp2_d     [CH_NUM];
    logic [OUT_W-1:0]   off2_q     [CH_NUM];
    logic [OUT_W-1:0]   off2_d     [CH_NUM];
    logic [SC_W-1:0]    scaled_q   [CH_NUM];
    logic [SC_W-1:0]    scaled_d   [CH_NUM];
    logic [OUT_W-1:0]   off3_q     [CH_NUM];
    logic [OUT_W-1:0]   off3_d     [CH_NUM];
    logic [OUT_W-1:0]   dout_q     [CH_NUM];
    logic [OUT_W-1:0]   dout_d     [CH_NUM];
    logic [1:0]         fill_q;
    logic [1:0]         fill_d;
    logic               out_valid_q;
    logic               out_valid_d;

`ifdef DDS_SINE_LUT_EN
    // Quarter-wave magnitude table; the two MSBs of the phase pick mirror and sign.
    logic [OUT_W-2:0] sine_rom [256];

    initial begin
        real pi_v;
        real amp_v;
        real ang;
        pi_v  = 3.14159265358979;
        amp_v = real'((1 << (OUT_W-1)) - 1);
        for (int i = 0; i < 256; i++) begin
            ang         = (pi_v / 2.0) * (real'(i) + 0.5) / 256.0;
            sine_rom[i] = (OUT_W-1)'($rtoi(amp_v * $sin(ang) + 0.5));
        end
    end

    function automatic logic [OUT_W-1:0] sine_lookup(input logic [PHASE_W-1:0] ph);
        logic [7:0]       idx;
        logic [OUT_W-1:0] mag;
        idx = ph[PHASE_W-2] ? ~ph[PHASE_W-3 -: 8] : ph[PHASE_W-3 -: 8];
        mag = {1'b0, sine_rom[idx]};
        return ph[PHASE_W-1] ? (HALF - mag) : (HALF + mag);
    endfunction
`endif

    function automatic cfg_t apply_write(input cfg_t cur, input logic [2:0] addr,
                                         input logic [31:0] wd);
        cfg_t             r;
        logic [AMP_W-1:0] amp;
        r   = cur;
        amp = wd[AMP_W-1:0];
        case (addr)
            3'd0:    r.freq   = wd[ACC_W-1:0];
            3'd1:    r.phase  = wd[PHASE_W-1:0];
            3'd2:    r.amp    = (amp > AMP_UNITY) ? AMP_UNITY : amp;
            3'd3:    r.offset = wd[OUT_W-1:0];
            3'd4:    r.mode   = wd[3:0];
            3'd5:    r.step   = wd[ACC_W-1:0];
            3'd6:    r.smax   = wd[ACC_W-1:0];
            default: r.sdiv   = wd[15:0];
        endcase
        return r;
    endfunction

    // A write in the same cycle as cfg_update lands in the commit.
    always_comb begin : cfg_comb
        for (int c = 0; c < CH_NUM; c++) begin
            shadow_d[c] = shadow_q[c];
            if (cfg_we && (int'(cfg_ch) == c)) begin
                shadow_d[c] = apply_write(shadow_q[c], cfg_addr, cfg_wdata);
            end
            active_d[c] = cfg_update ? shadow_d[c] : active_q[c];
        end
    end

    always_comb begin : sweep_comb
        logic [ACC_W:0] next_f;
        logic           wrap;
        next_f       = '0;
        wrap         = 1'b0;
        sweep_done_d = '0;
        for (int c = 0; c < CH_NUM; c++) begin
            next_f        = {1'b0, freq_cur_q[c]} + {1'b0, active_q[c].step};
            wrap          = (div_q[c] == active_q[c].sdiv);
            acc_d[c]      = cfg_sync ? '0 : acc_q[c] + freq_cur_q[c];
            freq_cur_d[c] = active_q[c].freq;
            div_d[c]      = '0;
            if (cfg_update) begin
                freq_cur_d[c] = shadow_d[c].freq;
            end else if (active_q[c].mode[3]) begin
                freq_cur_d[c] = freq_cur_q[c];
                div_d[c]      = div_q[c] + 16'd1;
                if (wrap) begin
                    div_d[c] = '0;
                    // A zero step would otherwise reload forever when FREQ sits above SWEEP_MAX.
                    if ((active_q[c].step != '0) && (next_f > {1'b0, active_q[c].smax})) begin
                        freq_cur_d[c]   = active_q[c].freq;
                        sweep_done_d[c] = 1'b1;
                    end else begin
                        freq_cur_d[c] = next_f[ACC_W-1:0];
                    end
                end
            end
        end
    end

    always_comb begin : wave_comb
        logic [PHASE_W-1:0] p;
        logic [OUT_W-1:0]   tri_v;
        p     = '0;
        tri_v = '0;
        for (int c = 0; c < CH_NUM; c++) begin
            meta1_d[c] = '{phase: active_q[c].phase, wave: active_q[c].mode[2:0],
                           amp: active_q[c].amp, offset: active_q[c].offset};
            p     = acc_q[c][ACC_W-1 -: PHASE_W] + meta1_q[c].phase;
            tri_v = p[PHASE_W-1] ? ~p[PHASE_W-2 -: OUT_W] : p[PHASE_W-2 -: OUT_W];
            case (meta1_q[c].wave)
                3'd0: begin
`ifdef DDS_SINE_LUT_EN
                    raw_d[c] = sine_lookup(p);
`else
                    raw_d[c] = tri_v;
`endif
                end
                3'd1:    raw_d[c] = p[PHASE_W-1] ? '0 : '1;
                3'd2:    raw_d[c] = tri_v;
                3'd3:    raw_d[c] = p[PHASE_W-1 -: OUT_W];
                default: raw_d[c] = '0;
            endcase
            amp2_d[c] = meta1_q[c].amp;
            off2_d[c] = meta1_q[c].offset;
        end
    end

    always_comb begin : scale_comb
        logic [PROD_W-1:0] prod;
        logic [SC_W:0]     sum;
        prod = '0;
        sum  = '0;
        for (int c = 0; c < CH_NUM; c++) begin
            prod        = raw_q[c] * amp2_q[c];
            scaled_d[c] = prod[PROD_W-1:8];
            off3_d[c]   = off2_q[c];
            sum         = {1'b0, scaled_q[c]} + {{(SC_W+1-OUT_W){1'b0}}, off3_q[c]};
            dout_d[c]   = (|sum[SC_W:OUT_W]) ? '1 : sum[OUT_W-1:0];
        end
    end

    always_comb begin : valid_comb
        fill_d      = (fill_q == 2'd3) ? fill_q : fill_q + 2'd1;
        out_valid_d = (fill_q == 2'd3);
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            for (int c = 0; c < CH_NUM; c++) begin
                shadow_q[c]   <= CFG_RST;
                active_q[c]   <= CFG_RST;
                acc_q[c]      <= '0;
                freq_cur_q[c] <= '0;
                div_q[c]      <= '0;
                meta1_q[c]    <= META_RST;
                raw_q[c]      <= '0;
                amp2_q[c]     <= AMP_UNITY;
                off2_q[c]     <= '0;
                scaled_q[c]   <= '0;
                off3_q[c]     <= '0;
                dout_q[c]     <= '0;
            end
            sweep_done_q <= '0;
            fill_q       <= '0;
            out_valid_q  <= 1'b0;
        end else begin
            for (int c = 0; c < CH_NUM; c++) begin
                shadow_q[c]   <= shadow_d[c];
                active_q[c]   <= active_d[c];
                acc_q[c]      <= acc_d[c];
                freq_cur_q[c] <= freq_cur_d[c];
                div_q[c]      <= div_d[c];
                meta1_q[c]    <= meta1_d[c];
                raw_q[c]      <= raw_d[c];
                amp2_q[c]     <= amp2_d[c];
                off2_q[c]     <= off2_d[c];
                scaled_q[c]   <= scaled_d[c];
                off3_q[c]     <= off3_d[c];
                dout_q[c]     <= dout_d[c];
            end
            sweep_done_q <= sweep_done_d;
            fill_q       <= fill_d;
            out_valid_q  <= out_valid_d;
        end
    end

    always_comb begin : out_comb
        data_out = '0;
        for (int c = 0; c < CH_NUM; c++) begin
            data_out[c*OUT_W +: OUT_W] = dout_q[c];
        end
    end

    assign out_valid  = out_valid_q;
    assign sweep_done = sweep_done_q;

endmodule

// File: tb/tb_dds_multi_ch.sv
// Bench for dds_multi_ch (default build): directed and random config traffic checked each cycle
// against a spec-level model of the channel behaviour.
module tb_dds_multi_ch;
  localparam int CH_NUM = 2;
  localparam int OUT_W  = 8;

  logic                    sys_clk = 1'b0;
  logic                    sys_rst = 1'b1;
  logic                    cfg_we = 1'b0;
  logic [0:0]              cfg_ch = '0;
  logic [2:0]              cfg_addr = '0;
  logic [31:0]             cfg_wdata = '0;
  logic                    cfg_update = 1'b0;
  logic                    cfg_sync = 1'b0;
  logic [CH_NUM*OUT_W-1:0] data_out;
  logic                    out_valid;
  logic [CH_NUM-1:0]       sweep_done;

  always #5 sys_clk = ~sys_clk;

  dds_multi_ch dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
    .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .cfg_update(cfg_update),
    .cfg_sync(cfg_sync), .data_out(data_out), .out_valid(out_valid),
    .sweep_done(sweep_done)
  );

  typedef struct packed {
    bit [31:0] freq;
    bit [31:0] step;
    bit [31:0] smax;
    bit [11:0] phase;
    bit [8:0]  amp;
    bit [7:0]  off;
    bit [3:0]  mode;
    bit [15:0] sdiv;
  } mcfg_t;

  int tests = 0;
  int fails = 0;

  mcfg_t     m_sh   [CH_NUM];
  mcfg_t     m_act  [CH_NUM];
  bit [31:0] m_acc  [CH_NUM];
  bit [31:0] m_fcur [CH_NUM];
  int        m_div  [CH_NUM];
  int        m_dly  [CH_NUM][3];
  int        m_exp  [CH_NUM];
  bit        m_done [CH_NUM];
  int        m_since_rst = 0;
  bit        m_valid = 1'b0;

  function automatic mcfg_t rst_cfg();
    mcfg_t r;
    r      = '0;
    r.amp  = 9'd256;
    r.smax = 32'hFFFF_FFFF;
    return r;
  endfunction

  // Expected output for one accumulator value under one configuration.
  function automatic int sample(input bit [31:0] acc, input mcfg_t cfg);
    int p, t, raw, v;
    p = (int'(acc >> 20) + int'(cfg.phase)) % 4096;
    t = (p / 8) % 256;
    case (int'(cfg.mode) % 8)
      0, 2:    raw = (p < 2048) ? t : 255 - t;
      1:       raw = (p < 2048) ? 255 : 0;
      3:       raw = p / 16;
      default: raw = 0;
    endcase
    v = (raw * int'(cfg.amp)) / 256 + int'(cfg.off);
    return (v > 255) ? 255 : v;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input bit rst, input bit we, input int ch, input int addr,
                            input bit [31:0] wd, input bit upd, input bit syn);
    mcfg_t     nsh [CH_NUM];
    bit [31:0] nacc;
    longint    nf;
    int        a;
    if (rst) begin
      for (int c = 0; c < CH_NUM; c++) begin
        m_sh[c] = rst_cfg(); m_act[c] = rst_cfg();
        m_acc[c] = 0; m_fcur[c] = 0; m_div[c] = 0; m_done[c] = 0; m_exp[c] = 0;
        for (int i = 0; i < 3; i++) m_dly[c][i] = 0;
      end
      m_since_rst = 0;
      m_valid     = 1'b0;
      return;
    end
    for (int c = 0; c < CH_NUM; c++) nsh[c] = m_sh[c];
    if (we && ch < CH_NUM) begin
      case (addr)
        0: nsh[ch].freq  = wd;
        1: nsh[ch].phase = wd[11:0];
        2: begin a = int'(wd % 512); nsh[ch].amp = (a > 256) ? 9'd256 : 9'(a); end
        3: nsh[ch].off   = wd[7:0];
        4: nsh[ch].mode  = wd[3:0];
        5: nsh[ch].step  = wd;
        6: nsh[ch].smax  = wd;
        default: nsh[ch].sdiv = wd[15:0];
      endcase
    end
    for (int c = 0; c < CH_NUM; c++) begin
      nacc = syn ? 32'd0 : m_acc[c] + m_fcur[c];
      m_exp[c]    = m_dly[c][0];
      m_dly[c][0] = m_dly[c][1];
      m_dly[c][1] = m_dly[c][2];
      m_dly[c][2] = sample(nacc, m_act[c]);
      m_acc[c]    = nacc;
      m_done[c]   = 1'b0;
      if (upd) begin
        m_act[c]  = nsh[c];
        m_fcur[c] = nsh[c].freq;
        m_div[c]  = 0;
      end else if (m_act[c].mode[3]) begin
        if (m_div[c] == int'(m_act[c].sdiv)) begin
          m_div[c] = 0;
          nf = longint'(m_fcur[c]) + longint'(m_act[c].step);
          if (m_act[c].step != 0 && nf > longint'(m_act[c].smax)) begin
            m_fcur[c] = m_act[c].freq;
            m_done[c] = 1'b1;
          end else begin
            m_fcur[c] = nf[31:0];
          end
        end else begin
          m_div[c]++;
        end
      end else begin
        m_fcur[c] = m_act[c].freq;
      end
      m_sh[c] = nsh[c];
    end
    m_since_rst++;
    m_valid = (m_since_rst >= 4);
  endtask

  task automatic cycle(input bit rst, input bit we, input int ch, input int addr,
                       input bit [31:0] wd, input bit upd, input bit syn);
    sys_rst    = rst;
    cfg_we     = we;
    cfg_ch     = 1'(ch);
    cfg_addr   = 3'(addr);
    cfg_wdata  = wd;
    cfg_update = upd;
    cfg_sync   = syn;
    @(posedge sys_clk);
    model_edge(rst, we, ch, addr, wd, upd, syn);
    @(negedge sys_clk);
    for (int c = 0; c < CH_NUM; c++) begin
      check($sformatf("data_out[%0d]", c), 32'(data_out[c*OUT_W +: OUT_W]), 32'(m_exp[c]));
      check($sformatf("sweep_done[%0d]", c), 32'(sweep_done[c]), 32'(m_done[c]));
    end
    check("out_valid", 32'(out_valid), 32'(m_valid));
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(1'b0, 1'b0, 0, 0, 32'd0, 1'b0, 1'b0);
  endtask

  task automatic wr(input int ch, input int addr, input bit [31:0] wd, input bit upd = 1'b0);
    cycle(1'b0, 1'b1, ch, addr, wd, upd, 1'b0);
  endtask

  initial begin
    @(negedge sys_clk);
    // reset and pipeline fill
    cycle(1'b1, 1'b0, 0, 0, 32'd0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 0, 0, 32'd0, 1'b0, 1'b0);
    idle(8);

    // sawtooth, one step per cycle, wraps every 256 cycles
    wr(0, 4, 32'd3);
    wr(0, 0, 32'h0100_0000, 1'b1);
    idle(300);

    // square with amplitude/offset, then saturating offset
    wr(0, 4, 32'd1);
    wr(0, 0, 32'h8000_0000);
    wr(0, 2, 32'd128);
    wr(0, 3, 32'd100, 1'b1);
    idle(12);
    wr(0, 3, 32'd200);
    wr(0, 2, 32'd256, 1'b1);
    idle(12);

    // random amplitude (incl. clamp range), offset, waveform and frequency
    repeat (5) begin
      wr(0, 2, $urandom_range(0, 511));
      wr(0, 3, $urandom_range(0, 255));
      wr(1, 4, $urandom_range(0, 7));
      wr(1, 0, $urandom);
      wr(0, 4, $urandom_range(0, 7));
      wr(0, 0, $urandom, 1'b1);
      idle(40);
    end

    // shadow write with no commit must not disturb the output
    wr(0, 4, 32'd3);
    wr(0, 2, 32'd256);
    wr(0, 3, 32'd0);
    wr(0, 0, 32'h0100_0000, 1'b1);
    idle(10);
    wr(0, 0, 32'h0300_0000);
    idle(50);
    cycle(1'b0, 1'b0, 0, 0, 32'd0, 1'b1, 1'b0);
    idle(10);

    // linear sweep on ch1: 1,2,3,4,1 x 2^28, then with a divider, then zero step
    wr(1, 0, 32'h1000_0000);
    wr(1, 5, 32'h1000_0000);
    wr(1, 6, 32'h4000_0000);
    wr(1, 7, 32'd0);
    wr(1, 2, 32'd256);
    wr(1, 3, 32'd0);
    wr(1, 4, 32'd11, 1'b1);
    idle(40);
    wr(1, 7, $urandom_range(1, 4), 1'b1);
    idle(80);
    wr(1, 5, 32'd0, 1'b1);
    idle(30);

    // reset in the middle of a running sweep
    wr(1, 7, 32'd0);
    wr(1, 5, 32'h1000_0000, 1'b1);
    idle(5);
    cycle(1'b1, 1'b0, 0, 0, 32'd0, 1'b0, 1'b0);
    idle(10);

    // phase-coherent pair: ch1 half a cycle ahead of ch0
    wr(0, 4, 32'd3);
    wr(1, 4, 32'd3);
    wr(0, 0, 32'h0100_0000);
    wr(1, 0, 32'h0100_0000);
    wr(1, 1, 32'h800);
    idle(7);
    cycle(1'b0, 1'b0, 0, 0, 32'd0, 1'b1, 1'b1);
    idle(300);

    // random register traffic with occasional commits and syncs
    repeat (400) begin
      int addr;
      bit [31:0] wd;
      addr = $urandom_range(0, 7);
      wd   = (addr == 7) ? 32'($urandom_range(0, 5)) : 32'($urandom);
      cycle(1'b0, 1'($urandom_range(0, 1)), $urandom_range(0, 1), addr, wd,
            ($urandom_range(0, 15) == 0), ($urandom_range(0, 31) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
